// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for the multicycle RV32I core. It sequences each instruction over 3-5 states
//   and drives the datapath enables and muxes. Memory accesses use a req/ready handshake,
//   with a wait counter that aborts an access after MEM_TIMEOUT idle cycles (0 = never).
//   The ALU decoder downstream consumes ALUOp.
// Optional feature (compile-time macro MULTICYCLE_CTRL_TRAP_EN):
//   defined   - an illegal encoding or a memory timeout enters TRAP, which holds illegal=1
//               until reset.
//   undefined - an illegal encoding flags illegal during DECODE only and then fetches the
//               next instruction; a timeout returns to FETCH.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   op, funct3          fields of the instruction register
//   mem_ready           memory completes the current request this cycle
//   mem_req, AdrSrc     memory request and address select (0 = PC, 1 = ALUOut)
//   IRWrite, PCUpdate   IR/OldPC load and PC write (fetch ones gated by mem_ready)
//   Branch, RegWrite    conditional PC write, register-file write
//   MemWrite            data write strobe (gated by mem_ready)
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   datapath mux selects
//   illegal, mem_err    illegal-instruction flag, one-cycle memory-timeout pulse
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpRtype  = 7'h33;
  localparam logic [6:0] OpItype  = 7'h13;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);
  localparam bit               TimeoutEn  = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBranch, StJal, StJalrT, StUpper
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , StTrap
`endif
  } state_e;

  // Where illegal encodings and memory timeouts land.
`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam state_e StFault = StTrap;
`else
  localparam state_e StFault = StFetch;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_op;
  logic             mem_state;
  logic             timeout;
  logic [2:0]       imm_src;

  always_comb begin
    illegal_op = 1'b0;
    case (op)
      OpLoad, OpStore, OpRtype, OpItype, OpJal, OpLui, OpAuipc: illegal_op = 1'b0;
      OpBranch: illegal_op = (funct3 == 3'b010) || (funct3 == 3'b011);
      OpJalr:   illegal_op = (funct3 != 3'b000);
      default:  illegal_op = 1'b1;
    endcase
  end

  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  // A ready in the timeout cycle still completes the access.
  assign timeout   = TimeoutEn && mem_state && !mem_ready && (cnt_q == TimeoutCnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        if (illegal_op) begin
          state_d = StFault;
        end else begin
          case (op)
            OpLoad, OpStore: state_d = StMemAdr;
            OpRtype:         state_d = StExecR;
            OpItype:         state_d = StExecI;
            OpBranch:        state_d = StBranch;
            OpJal:           state_d = StJal;
            OpJalr:          state_d = StJalrT;
            OpLui, OpAuipc:  state_d = StUpper;
            default:         state_d = StFault;
          endcase
        end
      end
      StMemAdr:  state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFault;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (mem_ready)    state_d = StFetch;
        else if (timeout) state_d = StFault;
      end
      StExecR, StExecI: state_d = StAluWb;
      StAluWb:          state_d = StFetch;
      StBranch:         state_d = StFetch;
      StJal:            state_d = StAluWb;
      StJalrT:          state_d = StJal;
      StUpper:          state_d = StAluWb;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      StTrap:           state_d = StTrap;
`endif
      default:          state_d = StIdle;
    endcase
  end

  // Count only while stalled inside a request state; any move (including a timeout
  // return to FETCH) restarts the count from zero.
  assign cnt_d = (mem_state && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    illegal   = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = illegal_op;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb:  RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      StJal: begin
        PCUpdate = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
      end
      StJalrT: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StUpper: begin
        ALUSrcA = (op == OpLui) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      StTrap:  illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mem_err = timeout;

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OpStore:       imm_src = 3'b001;
      OpBranch:      imm_src = 3'b010;
      OpJal:         imm_src = 3'b011;
      OpLui, OpAuipc: imm_src = 3'b100;
      default:       imm_src = 3'b000;
    endcase
  end

  // Immediate select is combinational from op but forced to I-type while in reset.
  assign ImmSrc = reset_n ? imm_src : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for the instruction
// flows plus hand-written sequences for memory timeouts, illegal encodings and reset.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
    logic       mem_err;
  } out_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal, mem_err;
  out_t       act;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];

  out_t e_idle, e_fetch_w, e_fetch_r, e_fetch_err, e_dec, e_dec_ill, e_memadr, e_memrd;
  out_t e_memrd_err, e_memwb, e_memwr_w, e_memwr_r, e_memwr_err, e_execr, e_execi, e_aluwb;
  out_t e_branch, e_jal, e_jalrt, e_lui, e_auipc, e_trap;

  multicycle_controller #(
    .MEM_TIMEOUT(15),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .funct3   (funct3),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .AdrSrc   (AdrSrc),
    .IRWrite  (IRWrite),
    .PCUpdate (PCUpdate),
    .Branch   (Branch),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ImmSrc   (ImmSrc),
    .illegal  (illegal),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, mem_err};

  // fl = {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite}
  function automatic out_t mk(input logic [6:0] fl, input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop, input logic ill,
                              input logic err);
    out_t o;
    o = {fl, rs, a, b, aop, 3'b000, ill, err};
    return o;
  endfunction

  function automatic out_t im(input out_t e, input logic [2:0] i);
    out_t o;
    o = e;
    o.imm_src = i;
    return o;
  endfunction

  task automatic check(input string nm, input out_t e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %b required %b", nm, act, e);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample shortly after.
  task automatic cyc(input logic [6:0] o, input logic [2:0] f, input logic r, input out_t e,
                     input string nm);
    @(negedge clk);
    op        = o;
    funct3    = f;
    mem_ready = r;
    #2;
    check(nm, e);
  endtask

  task automatic add(input logic [6:0] o, input logic [2:0] f, input logic r, input out_t e,
                     input logic [2:0] i);
    tbl.push_back({o, f, r, im(e, i)});
  endtask

  // Hold reset across a rising edge, check the reset outputs, release just after an edge.
  task automatic reset_cycle(input string nm);
    reset_n = 1'b0;
    op      = 7'h23;
    @(negedge clk);
    #2;
    check(nm, e_idle);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    e_idle      = mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_fetch_w   = mk(7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    e_fetch_r   = mk(7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    e_fetch_err = mk(7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
    e_dec       = mk(7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    e_dec_ill   = mk(7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0);
    e_memadr    = mk(7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    e_memrd     = mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_memrd_err = mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    e_memwb     = mk(7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_memwr_w   = mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_memwr_r   = mk(7'b1100001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_memwr_err = mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    e_execr     = mk(7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);
    e_execi     = mk(7'b0000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0);
    e_aluwb     = mk(7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_branch    = mk(7'b0000100, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
    e_jal       = mk(7'b0001000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
    e_jalrt     = mk(7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    e_lui       = mk(7'b0000000, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0);
    e_auipc     = mk(7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    e_trap      = mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

    // Per-cycle table, starting in IDLE right after reset release.
    add(7'h33, 3'd0, 1, e_idle, 3'd0);
    add(7'h33, 3'd0, 1, e_fetch_r, 3'd0); add(7'h33, 3'd0, 1, e_dec, 3'd0);
    add(7'h33, 3'd0, 1, e_execr, 3'd0);   add(7'h33, 3'd0, 1, e_aluwb, 3'd0);
    add(7'h13, 3'd0, 1, e_fetch_r, 3'd0); add(7'h13, 3'd0, 1, e_dec, 3'd0);
    add(7'h13, 3'd0, 1, e_execi, 3'd0);   add(7'h13, 3'd0, 1, e_aluwb, 3'd0);
    add(7'h63, 3'd0, 1, e_fetch_r, 3'd2); add(7'h63, 3'd0, 1, e_dec, 3'd2);
    add(7'h63, 3'd0, 1, e_branch, 3'd2);
    add(7'h6F, 3'd0, 1, e_fetch_r, 3'd3); add(7'h6F, 3'd0, 1, e_dec, 3'd3);
    add(7'h6F, 3'd0, 1, e_jal, 3'd3);     add(7'h6F, 3'd0, 1, e_aluwb, 3'd3);
    add(7'h67, 3'd0, 1, e_fetch_r, 3'd0); add(7'h67, 3'd0, 1, e_dec, 3'd0);
    add(7'h67, 3'd0, 1, e_jalrt, 3'd0);   add(7'h67, 3'd0, 1, e_jal, 3'd0);
    add(7'h67, 3'd0, 1, e_aluwb, 3'd0);
    add(7'h37, 3'd0, 1, e_fetch_r, 3'd4); add(7'h37, 3'd0, 1, e_dec, 3'd4);
    add(7'h37, 3'd0, 1, e_lui, 3'd4);     add(7'h37, 3'd0, 1, e_aluwb, 3'd4);
    add(7'h17, 3'd0, 1, e_fetch_r, 3'd4); add(7'h17, 3'd0, 1, e_dec, 3'd4);
    add(7'h17, 3'd0, 1, e_auipc, 3'd4);   add(7'h17, 3'd0, 1, e_aluwb, 3'd4);
    // Load with three wait cycles in MEMREAD.
    add(7'h03, 3'd2, 1, e_fetch_r, 3'd0); add(7'h03, 3'd2, 1, e_dec, 3'd0);
    add(7'h03, 3'd2, 1, e_memadr, 3'd0);
    add(7'h03, 3'd2, 0, e_memrd, 3'd0);   add(7'h03, 3'd2, 0, e_memrd, 3'd0);
    add(7'h03, 3'd2, 0, e_memrd, 3'd0);   add(7'h03, 3'd2, 1, e_memrd, 3'd0);
    add(7'h03, 3'd2, 1, e_memwb, 3'd0);
    // Store with one fetch wait cycle.
    add(7'h23, 3'd2, 0, e_fetch_w, 3'd1); add(7'h23, 3'd2, 1, e_fetch_r, 3'd1);
    add(7'h23, 3'd2, 1, e_dec, 3'd1);     add(7'h23, 3'd2, 1, e_memadr, 3'd1);
    add(7'h23, 3'd2, 1, e_memwr_r, 3'd1);
`ifndef MULTICYCLE_CTRL_TRAP_EN
    // Illegal encodings act as NOPs after one flagged DECODE cycle.
    add(7'h67, 3'd1, 1, e_fetch_r, 3'd0); add(7'h67, 3'd1, 1, e_dec_ill, 3'd0);
    add(7'h63, 3'd2, 1, e_fetch_r, 3'd2); add(7'h63, 3'd2, 1, e_dec_ill, 3'd2);
    add(7'h63, 3'd3, 1, e_fetch_r, 3'd2); add(7'h63, 3'd3, 1, e_dec_ill, 3'd2);
    add(7'h7F, 3'd0, 1, e_fetch_r, 3'd0); add(7'h7F, 3'd0, 1, e_dec_ill, 3'd0);
`endif
    add(7'h13, 3'd0, 1, e_fetch_r, 3'd0); add(7'h13, 3'd0, 1, e_dec, 3'd0);
    add(7'h13, 3'd0, 1, e_execi, 3'd0);   add(7'h13, 3'd0, 1, e_aluwb, 3'd0);

    funct3    = 3'd0;
    mem_ready = 1'b0;
    reset_cycle("reset_state");

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].op, tbl[i].f3, tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Store that never gets ready: mem_err in the 16th MEMWRITE cycle, no write strobe.
    cyc(7'h23, 3'd2, 1, im(e_fetch_r, 3'd1), "st_to_fetch");
    cyc(7'h23, 3'd2, 1, im(e_dec, 3'd1), "st_to_dec");
    cyc(7'h23, 3'd2, 1, im(e_memadr, 3'd1), "st_to_adr");
    for (int i = 1; i <= 15; i++) begin
      cyc(7'h23, 3'd2, 0, im(e_memwr_w, 3'd1), $sformatf("st_wait%0d", i));
    end
    cyc(7'h23, 3'd2, 0, im(e_memwr_err, 3'd1), "st_timeout");

`ifdef MULTICYCLE_CTRL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(7'h33, 3'd0, 1, e_trap, $sformatf("to_trap%0d", i));
    reset_cycle("reset_after_trap");
    cyc(7'h7F, 3'd0, 1, e_idle, "ill_idle");
    cyc(7'h7F, 3'd0, 1, e_fetch_r, "ill_fetch");
    cyc(7'h7F, 3'd0, 1, e_dec_ill, "ill_dec");
    for (int i = 0; i < 4; i++) cyc(7'h7F, 3'd0, 1, e_trap, $sformatf("ill_trap%0d", i));
    reset_cycle("reset_after_ill");
    cyc(7'h33, 3'd0, 1, e_idle, "post_trap_idle");
`else
    // Timeout returns to FETCH; a fetch timeout then restarts the count.
    for (int i = 1; i <= 15; i++) begin
      cyc(7'h33, 3'd0, 0, e_fetch_w, $sformatf("f_wait%0d", i));
    end
    cyc(7'h33, 3'd0, 0, e_fetch_err, "f_timeout");
    cyc(7'h33, 3'd0, 0, e_fetch_w, "f_after_timeout");
    cyc(7'h33, 3'd0, 1, e_fetch_r, "f_ready");
    cyc(7'h33, 3'd0, 1, e_dec, "f_dec");
    cyc(7'h33, 3'd0, 1, e_execr, "f_exec");
    cyc(7'h33, 3'd0, 1, e_aluwb, "f_wb");
`endif

    // Reset mid-fetch drops the request at once, then IDLE, then FETCH.
    cyc(7'h33, 3'd0, 0, e_fetch_w, "rst_fetch_wait");
    #1 reset_n = 1'b0;
    #1 check("rst_drop", e_idle);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(7'h33, 3'd0, 1, e_idle, "rst_idle");
    cyc(7'h33, 3'd0, 1, e_fetch_r, "rst_fetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
